// File: rtl/control_unit.sv
// control_unit: ARM-subset single-cycle control decoder with conditional execution and an NZCV flag register
//   clk, reset (async, active-high) | Instr[31:12] = {Cond, Op, Funct, Rn, Rd} | ALUFlags = {N,Z,C,V}
//   RegSrc, ImmSrc, ALUSrc, ALUControl, MemtoReg: datapath selects
//   RegWrite, MemWrite, PCSrc: condition-gated strobes | Flags: stored NZCV
module control_unit (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:12] Instr,
  input  logic [3:0]   ALUFlags,
  output logic [1:0]   RegSrc,
  output logic         RegWrite,
  output logic [1:0]   ImmSrc,
  output logic         ALUSrc,
  output logic [1:0]   ALUControl,
  output logic         MemtoReg,
  output logic         MemWrite,
  output logic         PCSrc,
  output logic [3:0]   Flags
);
  logic [3:0] cond, rd, flags_q, flags_d;
  logic [1:0] op, flag_w;
  logic [5:0] funct;
  logic       reg_w, mem_w, branch, no_write, cond_ex, pcs, n, z, c, v;
  logic       unused_rn;
  assign cond      = Instr[31:28];
  assign op        = Instr[27:26];
  assign funct     = Instr[25:20];
  assign rd        = Instr[15:12];
  assign unused_rn = ^Instr[19:16];
  assign {n, z, c, v} = flags_q;
  always_comb begin
    RegSrc     = 2'b00;
    ImmSrc     = 2'b00;
    ALUSrc     = 1'b0;
    ALUControl = 2'b00;
    MemtoReg   = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    branch     = 1'b0;
    flag_w     = 2'b00;
    no_write   = 1'b0;
    case (op)
      2'b00: begin
        ALUSrc = funct[5];
        reg_w  = 1'b1;
        case (funct[4:1])
          4'b0100: flag_w = {2{funct[0]}};
          4'b0010: begin
            ALUControl = 2'b01;
            flag_w     = {2{funct[0]}};
          end
          4'b0000: begin
            ALUControl = 2'b10;
            flag_w     = {funct[0], 1'b0};
          end
          4'b1100: begin
            ALUControl = 2'b11;
            flag_w     = {funct[0], 1'b0};
          end
          // CMP always sets all flags and never writes the register file
          4'b1010: begin
            ALUControl = 2'b01;
            flag_w     = 2'b11;
            no_write   = 1'b1;
          end
          default: no_write = 1'b1;
        endcase
      end
      // memory: funct[0] is L (1 = load); U bit is ignored, offset always added
      2'b01: begin
        ImmSrc   = 2'b01;
        ALUSrc   = 1'b1;
        RegSrc   = funct[0] ? 2'b00 : 2'b10;
        MemtoReg = funct[0];
        reg_w    = funct[0];
        mem_w    = ~funct[0];
      end
      2'b10: begin
        RegSrc = 2'b01;
        ImmSrc = 2'b10;
        ALUSrc = 1'b1;
        branch = 1'b1;
      end
      default: ;
    endcase
  end
  always_comb begin
    case (cond)
      4'h0:    cond_ex = z;
      4'h1:    cond_ex = ~z;
      4'h2:    cond_ex = c;
      4'h3:    cond_ex = ~c;
      4'h4:    cond_ex = n;
      4'h5:    cond_ex = ~n;
      4'h6:    cond_ex = v;
      4'h7:    cond_ex = ~v;
      4'h8:    cond_ex = c & ~z;
      4'h9:    cond_ex = ~c | z;
      4'ha:    cond_ex = n ~^ v;
      4'hb:    cond_ex = n ^ v;
      4'hc:    cond_ex = ~z & (n ~^ v);
      4'hd:    cond_ex = z | (n ^ v);
      4'he:    cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end
  // a write to R15 is a jump, so PC loads from Result as well
  assign pcs      = branch | (reg_w & (rd == 4'hf));
  assign PCSrc    = pcs & cond_ex & ~reset;
  assign RegWrite = reg_w & ~no_write & cond_ex & ~reset;
  assign MemWrite = mem_w & cond_ex & ~reset;
  assign flags_d  = {(flag_w[1] & cond_ex) ? ALUFlags[3:2] : flags_q[3:2],
                     (flag_w[0] & cond_ex) ? ALUFlags[1:0] : flags_q[1:0]};
  always_ff @(posedge clk or posedge reset)
    if (reset) flags_q <= 4'b0000;
    else       flags_q <= flags_d;
  assign Flags = flags_q;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed scenarios plus randomized checking against a behavioural decode model
module tb_control_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] ins = 20'h0;
  logic [3:0]  alu_flags = 4'h0;
  logic [1:0]  reg_src, imm_src, alu_control;
  logic        reg_write, alu_src, memto_reg, mem_write, pc_src;
  logic [3:0]  flags;
  int          tests = 0;
  int          fails = 0;
  control_unit dut (
    .clk(clk), .reset(reset), .Instr(ins), .ALUFlags(alu_flags),
    .RegSrc(reg_src), .RegWrite(reg_write), .ImmSrc(imm_src), .ALUSrc(alu_src),
    .ALUControl(alu_control), .MemtoReg(memto_reg), .MemWrite(mem_write),
    .PCSrc(pc_src), .Flags(flags)
  );
  always #5 clk = ~clk;
  function automatic bit cond_pass(logic [3:0] cnd, logic [3:0] f);
    bit nn, zz, cc, vv, base;
    {nn, zz, cc, vv} = f;
    if (cnd == 4'hf) return 1'b0;
    case (cnd[3:1])
      3'd0: base = zz;
      3'd1: base = cc;
      3'd2: base = nn;
      3'd3: base = vv;
      3'd4: base = cc && !zz;
      3'd5: base = (nn == vv);
      3'd6: base = !zz && (nn == vv);
      default: return 1'b1;
    endcase
    return cnd[0] ? !base : base;
  endfunction
  // expected {RegSrc,RegWrite,ImmSrc,ALUSrc,ALUControl,MemtoReg,MemWrite,PCSrc}; mask = NZCV bits written
  function automatic logic [11:0] model(logic [19:0] i, logic [3:0] f, logic rs, output logic [3:0] mask);
    logic [1:0] rsrc, isrc, aluc;
    bit asrc, m2r, wr_reg, wr_mem, jump, ok, s;
    int kind, cmd;
    rsrc = 0; isrc = 0; aluc = 0; asrc = 0; m2r = 0; wr_reg = 0; wr_mem = 0; jump = 0; mask = 0;
    kind = int'(i[15:14]);
    cmd  = int'(i[12:9]);
    s    = i[8];
    ok   = cond_pass(i[19:16], f);
    if (kind == 0) begin
      asrc = i[13];
      if (cmd == 4)       begin aluc = 0; wr_reg = 1; mask = s ? 4'b1111 : 4'b0000; end
      else if (cmd == 2)  begin aluc = 1; wr_reg = 1; mask = s ? 4'b1111 : 4'b0000; end
      else if (cmd == 0)  begin aluc = 2; wr_reg = 1; mask = s ? 4'b1100 : 4'b0000; end
      else if (cmd == 12) begin aluc = 3; wr_reg = 1; mask = s ? 4'b1100 : 4'b0000; end
      else if (cmd == 10) begin aluc = 1; mask = 4'b1111; end
      jump = (i[3:0] == 4'hf);
    end else if (kind == 1) begin
      isrc = 1; asrc = 1;
      if (i[8]) begin m2r = 1; wr_reg = 1; jump = (i[3:0] == 4'hf); end
      else begin rsrc = 2; wr_mem = 1; end
    end else if (kind == 2) begin
      rsrc = 1; isrc = 2; asrc = 1; jump = 1;
    end
    if (!ok) mask = 0;
    ok = ok && !rs;
    return {rsrc, wr_reg && ok, isrc, asrc, aluc, m2r, wr_mem && ok, jump && ok};
  endfunction
  task automatic test_reset();
    reset = 1'b1; ins = 20'hE2800; alu_flags = 4'h0;
    @(negedge clk);
    tests++; if (reg_write !== 1'b0) begin fails++; $display("FAIL reset_regwrite got %b want 0", reg_write); end
    tests++; if (flags !== 4'b0000) begin fails++; $display("FAIL reset_flags got %b want 0000", flags); end
    reset = 1'b0; #1;
    tests++;
    if ({reg_write, alu_src, imm_src, alu_control, pc_src} !== 7'b1_1_00_00_0) begin
      fails++; $display("FAIL release_add got %b want 1100000", {reg_write, alu_src, imm_src, alu_control, pc_src});
    end
  endtask
  task automatic test_flag_branch();
    @(negedge clk); ins = 20'hE2510; alu_flags = 4'b0100;
    @(posedge clk); #1;
    tests++; if (flags !== 4'b0100) begin fails++; $display("FAIL subs_flags got %b want 0100", flags); end
    ins = 20'h0A000; #1;
    tests++;
    if ({pc_src, imm_src, reg_src, reg_write} !== 6'b1_10_01_0) begin
      fails++; $display("FAIL beq got %b want 110010", {pc_src, imm_src, reg_src, reg_write});
    end
    ins = 20'h1A000; #1;
    tests++; if (pc_src !== 1'b0) begin fails++; $display("FAIL bne_pcsrc got %b want 0", pc_src); end
  endtask
  task automatic test_memory();
    @(negedge clk); ins = 20'hE5801; #1;
    tests++;
    if ({mem_write, reg_write, reg_src, imm_src, alu_src} !== 7'b1_0_10_01_1) begin
      fails++; $display("FAIL str got %b want 1010011", {mem_write, reg_write, reg_src, imm_src, alu_src});
    end
    ins = 20'hE5901; #1;
    tests++;
    if ({memto_reg, reg_write, mem_write} !== 3'b110) begin
      fails++; $display("FAIL ldr got %b want 110", {memto_reg, reg_write, mem_write});
    end
  endtask
  task automatic test_cmp_signed();
    @(negedge clk); ins = 20'hE3500; alu_flags = 4'b1000; #1;
    tests++;
    if ({reg_write, alu_control} !== 3'b0_01) begin
      fails++; $display("FAIL cmp_decode got %b want 001", {reg_write, alu_control});
    end
    @(posedge clk); #1;
    tests++; if (flags !== 4'b1000) begin fails++; $display("FAIL cmp_flags got %b want 1000", flags); end
    ins = 20'hBA000; #1;
    tests++; if (pc_src !== 1'b1) begin fails++; $display("FAIL blt_pcsrc got %b want 1", pc_src); end
    ins = 20'hAA000; #1;
    tests++; if (pc_src !== 1'b0) begin fails++; $display("FAIL bge_pcsrc got %b want 0", pc_src); end
  endtask
  task automatic test_failed_cond();
    @(negedge clk); reset = 1'b1; #1;
    reset = 1'b0; ins = 20'h02900; alu_flags = 4'b1111; #1;
    tests++;
    if ({reg_write, pc_src} !== 2'b00) begin
      fails++; $display("FAIL addeqs_strobes got %b want 00", {reg_write, pc_src});
    end
    @(posedge clk); #1;
    tests++; if (flags !== 4'b0000) begin fails++; $display("FAIL addeqs_flags got %b want 0000", flags); end
  endtask
  task automatic test_pc_undef();
    @(negedge clk); ins = 20'hE28FF; #1;
    tests++;
    if ({reg_write, pc_src} !== 2'b11) begin
      fails++; $display("FAIL add_pc got %b want 11", {reg_write, pc_src});
    end
    ins = 20'hEC000; #1;
    tests++;
    if ({reg_write, mem_write, pc_src} !== 3'b000) begin
      fails++; $display("FAIL undef_op got %b want 000", {reg_write, mem_write, pc_src});
    end
    ins = 20'hE2900; alu_flags = 4'b1111;
    @(posedge clk); #1;
    tests++; if (flags !== 4'b1111) begin fails++; $display("FAIL adds_all got %b want 1111", flags); end
    reset = 1'b1; #1;
    tests++; if (flags !== 4'b0000) begin fails++; $display("FAIL async_reset got %b want 0000", flags); end
    tests++; if (reg_write !== 1'b0) begin fails++; $display("FAIL reset_gate got %b want 0", reg_write); end
    @(negedge clk); reset = 1'b0;
  endtask
  task automatic test_random();
    logic [3:0]  mflags, mask;
    logic [11:0] exp_out;
    mflags = 4'b0000;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      reset = (k == 0) || ($urandom_range(0, 29) == 0);
      ins = 20'($urandom);
      if ($urandom_range(0, 1) == 0) ins[19:16] = 4'hE;
      alu_flags = 4'($urandom);
      if (reset) mflags = 4'b0000;
      #1;
      exp_out = model(ins, mflags, reset, mask);
      tests++;
      if ({reg_src, reg_write, imm_src, alu_src, alu_control, memto_reg, mem_write, pc_src} !== exp_out) begin
        fails++;
        $display("FAIL rand_decode ins=%h flags=%b got %b want %b", ins, mflags,
                 {reg_src, reg_write, imm_src, alu_src, alu_control, memto_reg, mem_write, pc_src}, exp_out);
      end
      @(posedge clk);
      if (!reset) mflags = (mflags & ~mask) | (alu_flags & mask);
      #1;
      tests++;
      if (flags !== mflags) begin
        fails++; $display("FAIL rand_flags ins=%h alu=%b got %b want %b", ins, alu_flags, flags, mflags);
      end
    end
    reset = 1'b0;
  endtask
  initial begin
    test_reset();
    test_flag_branch();
    test_memory();
    test_cmp_signed();
    test_failed_cond();
    test_pc_undef();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/control_unit.md
# control_unit

Control unit for the single-cycle ARM-subset processor. It decodes the instruction word from instruction memory and drives every control input of the single-cycle datapath: RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl, MemtoReg and PCSrc. It also drives MemWrite for data memory. It holds the architectural NZCV flag register, evaluates the instruction condition field against it, and gates all state-changing strobes, so conditional execution and flag-setting work without changing the datapath.

## Interface
- No parameters (fixed 32-bit ARM subset).
- clk  input  1  system clock; the flag register updates on the rising edge.
- reset  input  1  asynchronous, active-high.
- Instr  input  20  Instr[31:12] of the current instruction: Cond[31:28], Op[27:26], Funct[25:20], Rd[15:12].
- ALUFlags  input  4  current-cycle ALU flags {N,Z,C,V}, bit 3 = N.
- RegSrc  output  2  register-file read-address mux selects.
- RegWrite  output  1  register-file write enable, after condition gating.
- ImmSrc  output  2  extend select: 00 imm8, 01 imm12, 10 imm24 branch.
- ALUSrc  output  1  1 = extended immediate on SrcB.
- ALUControl  output  2  00 ADD, 01 SUB, 10 AND, 11 ORR.
- MemtoReg  output  1  1 = write back ReadData.
- MemWrite  output  1  data-memory write enable, after condition gating.
- PCSrc  output  1  1 = load PC from Result, after condition gating.
- Flags  output  4  stored NZCV register, same bit order as ALUFlags.

## Operation
- **Main decode by Op**
  - Op 00, data-processing: RegSrc=00, ImmSrc=00, ALUSrc=Funct[5], MemtoReg=0, RegW=1, MemW=0, Branch=0.
  - Op 01, memory, with L=Funct[0]:
    - Common to both: ImmSrc=01, ALUSrc=1, ALUControl=ADD. The U bit is ignored.
    - STR (L=0): RegSrc=10, MemW=1, RegW=0.
    - LDR (L=1): RegSrc=00, MemtoReg=1, RegW=1, MemW=0.
  - Op 10, branch: RegSrc=01, ImmSrc=10, ALUSrc=1, ALUControl=ADD, Branch=1, RegW=0, MemW=0.
  - Op 11, undefined: RegW=MemW=Branch=0, FlagW=00. Other outputs are 0.
- **ALU decode** (Op 00 only), cmd=Funct[4:1], S=Funct[0]:
  - 0100 ADD → ALUControl 00, FlagW={S,S}.
  - 0010 SUB → ALUControl 01, FlagW={S,S}.
  - 0000 AND → ALUControl 10, FlagW={S,0}.
  - 1100 ORR → ALUControl 11, FlagW={S,0}.
  - 1010 CMP → ALUControl 01, FlagW=11 regardless of S, NoWrite=1.
  - Any other cmd → ALUControl 00, FlagW=00, NoWrite=1.
- **PC source**: PCS = Branch | (RegW & Rd==4'hF).
- **Condition check** on the stored Flags (N,Z,C,V):
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z.
  - GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL 1; Cond 1111 gives CondEx=0.
- **Gated outputs**:
  - PCSrc = PCS & CondEx.
  - RegWrite = RegW & !NoWrite & CondEx.
  - MemWrite = MemW & CondEx.
- **Flag register**, on each rising edge when CondEx=1:
  - If FlagW[1]=1: Flags[3:2] ← ALUFlags[3:2].
  - If FlagW[0]=1: Flags[1:0] ← ALUFlags[1:0].
  - Bits not enabled hold their value.

## Timing
- Decode and gating are combinational, with zero-cycle latency from Instr/ALUFlags to outputs.
- An instruction evaluates its own condition against the flags stored before it. Flags it sets are visible from the next cycle.
- **Reset**:
  - Flags ← 0000 immediately, regardless of clk.
  - While reset=1, RegWrite, MemWrite and PCSrc are forced to 0. Remaining outputs follow decode.
  - Reset asserted mid-sequence discards all flag history. After release, the first instruction sees Flags=0000, so EQ fails and NE passes.
- A flag-setting instruction whose condition fails leaves Flags unchanged and produces no strobes.
- Data-processing with Rd=15 and CondEx=1 asserts both RegWrite=1 and PCSrc=1 in the same cycle.

## Test plan
- **Reset**: hold reset with Instr[31:12]=E2800 (ADD R0,R0,#5) → RegWrite=0, Flags=0000. Release reset → RegWrite=1, ALUSrc=1, ImmSrc=00, ALUControl=00, PCSrc=0.
- **Flag set, then conditional branch**:
  - Apply SUBS E2510 with ALUFlags=0100, clock once → Flags=0100.
  - Apply BEQ 0A000 → PCSrc=1, ImmSrc=10, RegSrc=01, RegWrite=0.
  - Apply BNE 1A000 → PCSrc=0.
- **Memory decode**:
  - STR E5801 → MemWrite=1, RegWrite=0, RegSrc=10, ImmSrc=01, ALUSrc=1.
  - LDR E5901 → MemtoReg=1, RegWrite=1, MemWrite=0.
- **CMP and signed branch**:
  - Apply CMP E3500 with ALUFlags=1000 → RegWrite=0, ALUControl=01; after the edge Flags=1000.
  - Apply BLT BA000 → PCSrc=1. Apply BGE AA000 → PCSrc=0.
- **Failed condition**: with Flags=0000, apply ADDEQS 02900 with ALUFlags=1111 → RegWrite=0, PCSrc=0, and Flags remains 0000 after the edge.
- **PC write and undefined op**:
  - ADD PC E28FF with AL → RegWrite=1 and PCSrc=1.
  - Op 11 (EC000) → RegWrite=MemWrite=PCSrc=0.
  - Assert reset mid-run with Flags=1111 → Flags=0000 before the next edge.
